// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Owns the fetch PC of a dual-issue front end and applies branch redirects
//   resolved in EX. A redirect that arrives while IF/ID is stalled is parked
//   in a pending register (state PEND). It is applied on the first cycle
//   without a stall.
//
// Parameters
//   RESET_PC      fetch PC loaded on reset
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   stall         IF/ID hold request (e.g. load-use)
//   taken1/2      EX slot-1 / slot-2 branch resolved taken (slot 1 has priority)
//   target1/2     slot-1 / slot-2 branch target (bits [1:0] ignored)
//   pc            registered fetch PC
//   fetch_valid2  second fetch slot valid (~pc[2])
//   flush_if      squash IF/ID (redirect accepted in RUN, or any PEND cycle)
//   flush_id      squash ID/EX (redirect accepted in RUN)
//   kill_ex2      squash slot-2 result in EX (slot 2 is younger than slot 1)
//   redirect      registered pulse: PC was redirected at the last edge
//   taken_count   saturating count of accepted redirects
//
// Configuration
//   BRANCH_STATS_EN  when defined, taken_count is a live saturating counter.
//                    When undefined, it is tied to zero and has no flops.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        taken1,
  input  logic        taken2,
  input  logic [31:0] target1,
  input  logic [31:0] target2,
  output logic [31:0] pc,
  output logic        fetch_valid2,
  output logic        flush_if,
  output logic        flush_id,
  output logic        kill_ex2,
  output logic        redirect,
  output logic [31:0] taken_count
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redirect_q, redirect_d;

  logic        any_taken;
  logic        accept;
  logic [31:0] sel_target;
  logic [31:0] pc_seq;

  always_comb begin
    any_taken  = taken1 | taken2;
    accept     = (state_q == RUN) && any_taken;
    sel_target = taken1 ? {target1[31:2], 2'b00} : {target2[31:2], 2'b00};
    // An odd-word PC only has one slot left in its 8-byte fetch group.
    pc_seq     = pc_q + (pc_q[2] ? 32'd4 : 32'd8);

    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    redirect_d = 1'b0;

    case (state_q)
      RUN: begin
        if (any_taken) begin
          if (stall) begin
            pend_d  = sel_target;
            state_d = PEND;
          end else begin
            pc_d       = sel_target;
            redirect_d = 1'b1;
          end
        end else if (!stall) begin
          pc_d = pc_seq;
        end
      end
      PEND: begin
        // New branches in PEND are not expected and are ignored here.
        if (!stall) begin
          pc_d       = pend_q;
          state_d    = RUN;
          redirect_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      redirect_q <= redirect_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count_q, taken_count_d;

  always_comb begin
    taken_count_d = taken_count_q;
    if (accept && (taken_count_q != '1)) begin
      taken_count_d = taken_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count_q <= '0;
    end else begin
      taken_count_q <= taken_count_d;
    end
  end

  assign taken_count = taken_count_q;
`else
  assign taken_count = '0;
`endif

  assign pc           = pc_q;
  assign fetch_valid2 = ~pc_q[2];
  assign flush_if     = accept || (state_q == PEND);
  assign flush_id     = accept;
  assign kill_ex2     = taken1;
  assign redirect     = redirect_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        taken1;
  logic        taken2;
  logic [31:0] target1;
  logic [31:0] target2;
  logic [31:0] pc;
  logic        fetch_valid2;
  logic        flush_if;
  logic        flush_id;
  logic        kill_ex2;
  logic        redirect;
  logic [31:0] taken_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = '0;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  branch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .taken1       (taken1),
    .taken2       (taken2),
    .target1      (target1),
    .target2      (target2),
    .pc           (pc),
    .fetch_valid2 (fetch_valid2),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .kill_ex2     (kill_ex2),
    .redirect     (redirect),
    .taken_count  (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A new branch while PEND (flush_if without flush_id) is illegal stimulus.
  always @(posedge clk) begin
    assert (rst || !(flush_if && !flush_id && (taken1 || taken2)))
      else $error("FAIL pend_taken: branch asserted while in PEND");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    checks++;
    if (taken_count !== (STATS ? exp_cnt : 32'h0)) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, taken_count,
               (STATS ? exp_cnt : 32'h0));
    end
  endtask

  task automatic clear_taken;
    taken1 = 1'b0;
    taken2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; clear_taken();
    target1 = '0; target2 = '0;
    step(); step();
    chk32("reset_pc", pc, 32'h0);
    chk1("reset_redirect", redirect, 1'b0);
    chk_cnt("reset_count");
    chk1("reset_flush_if", flush_if, 1'b0);
    chk1("reset_flush_id", flush_id, 1'b0);
    chk1("reset_kill_ex2", kill_ex2, 1'b0);
    chk1("reset_fv2", fetch_valid2, 1'b1);
  endtask

  task automatic test_sequential;
    rst = 1'b0;
    #1;
    chk32("seq_pc0", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk32("seq_pc", pc, 32'(8 * i));
      chk1("seq_fv2", fetch_valid2, 1'b1);
    end
  endtask

  task automatic test_stall_hold;
    stall = 1'b1;
    step(); step();
    chk32("stall_hold_pc", pc, 32'h18);
    chk1("stall_hold_flush_if", flush_if, 1'b0);
    stall = 1'b0;
  endtask

  task automatic test_dual_taken;
    taken1 = 1'b1; taken2 = 1'b1;
    target1 = 32'h100; target2 = 32'h200;
    #1;
    chk1("dual_flush_if", flush_if, 1'b1);
    chk1("dual_flush_id", flush_id, 1'b1);
    chk1("dual_kill_ex2", kill_ex2, 1'b1);
    step();
    clear_taken();
    exp_cnt++;
    chk32("dual_pc", pc, 32'h100);
    chk1("dual_redirect", redirect, 1'b1);
    chk_cnt("dual_count");
    step();
    chk32("dual_pc_next", pc, 32'h108);
    chk1("dual_redirect_off", redirect, 1'b0);
  endtask

  task automatic test_misaligned;
    taken2 = 1'b1; target2 = 32'h107; target1 = 32'h300;
    #1;
    chk1("mis_kill_ex2", kill_ex2, 1'b0);
    chk1("mis_flush_id", flush_id, 1'b1);
    step();
    clear_taken();
    exp_cnt++;
    chk32("mis_pc", pc, 32'h104);
    chk1("mis_fv2", fetch_valid2, 1'b0);
    chk1("mis_redirect", redirect, 1'b1);
    chk_cnt("mis_count");
    step();
    chk32("mis_pc_next", pc, 32'h108);
    chk1("mis_fv2_next", fetch_valid2, 1'b1);
  endtask

  task automatic test_stalled_redirect;
    stall = 1'b1; taken1 = 1'b1; target1 = 32'h40;
    #1;
    chk1("stl_flush_if_run", flush_if, 1'b1);
    chk1("stl_flush_id_run", flush_id, 1'b1);
    step();
    clear_taken();
    exp_cnt++;
    chk32("stl_pc_hold", pc, 32'h108);
    chk1("stl_flush_if_pend", flush_if, 1'b1);
    chk1("stl_flush_id_pend", flush_id, 1'b0);
    chk1("stl_redirect_pend", redirect, 1'b0);
    chk_cnt("stl_count");
    for (int i = 0; i < 2; i++) begin
      step();
      chk32("stl_pc_hold_loop", pc, 32'h108);
      chk1("stl_flush_if_loop", flush_if, 1'b1);
    end
    stall = 1'b0;
    #1;
    chk1("stl_flush_if_release", flush_if, 1'b1);
    step();
    chk32("stl_pc_target", pc, 32'h40);
    chk1("stl_redirect", redirect, 1'b1);
    chk1("stl_flush_if_run_again", flush_if, 1'b0);
    step();
    chk32("stl_pc_after", pc, 32'h48);
    chk1("stl_redirect_once", redirect, 1'b0);
    chk_cnt("stl_count_after");
  endtask

  task automatic test_reset_in_pend;
    stall = 1'b1; taken1 = 1'b1; target1 = 32'h80;
    step();
    clear_taken();
    chk1("rp_in_pend", flush_if, 1'b1);
    rst = 1'b1;
    step();
    exp_cnt = '0;
    chk32("rp_pc", pc, 32'h0);
    chk1("rp_run", flush_if, 1'b0);
    chk1("rp_redirect", redirect, 1'b0);
    chk_cnt("rp_count");
    rst = 1'b0; stall = 1'b0;
    step();
    chk32("rp_pc_seq1", pc, 32'h8);
    chk1("rp_no_redirect", redirect, 1'b0);
    step();
    chk32("rp_pc_seq2", pc, 32'h10);
  endtask

  task automatic test_wrap;
    taken1 = 1'b1; target1 = 32'hFFFF_FFFB;
    step();
    clear_taken();
    exp_cnt++;
    chk32("wrap_pc_f8", pc, 32'hFFFF_FFF8);
    chk1("wrap_fv2_f8", fetch_valid2, 1'b1);
    step();
    chk32("wrap_pc_0", pc, 32'h0);
    taken1 = 1'b1; target1 = 32'hFFFF_FFFE;
    step();
    clear_taken();
    exp_cnt++;
    chk32("wrap_pc_fc", pc, 32'hFFFF_FFFC);
    chk1("wrap_fv2_fc", fetch_valid2, 1'b0);
    step();
    chk32("wrap_pc_0b", pc, 32'h0);
    chk_cnt("wrap_count");
  endtask

  task automatic test_saturation;
`ifdef BRANCH_STATS_EN
    force dut.taken_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count_q;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    taken1 = 1'b1; target1 = 32'h200;
    step();
    clear_taken();
    chk32("sat_pc", pc, 32'h200);
    chk_cnt("sat_count");
    step();
    chk_cnt("sat_count_hold");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_dual_taken();
    test_misaligned();
    test_stalled_redirect();
    test_reset_in_pend();
    test_wrap();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning fetch PC loaded on reset.
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  IF/ID hold request, e.g. load-use.
- taken1  in  1  EX slot-1 branch resolved taken.
- taken2  in  1  EX slot-2 branch resolved taken.
- target1  in  32  slot-1 branch target.
- target2  in  32  slot-2 branch target.
- pc  out  32  fetch PC, registered.
- fetch_valid2  out  1  second fetch slot valid.
- flush_if  out  1  squash IF/ID register contents.
- flush_id  out  1  squash ID/EX register contents.
- kill_ex2  out  1  squash slot-2 result in EX.
- redirect  out  1  registered pulse, PC was redirected last edge.
- taken_count  out  32  accepted-redirect counter.
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high, on port rst.

Function
REQ-004 States SHALL be RUN and PEND; reset state SHALL be RUN.
REQ-005 Accepted redirect: taken1 = 1 selects target1; else taken2 = 1 selects target2; slot 1 SHALL always have priority.
REQ-006 Target bits [1:0] SHALL be forced to 00 before use.
REQ-007 RUN, no taken, stall = 0: pc SHALL advance by 8 if pc[2] = 0, else by 4.
REQ-008 RUN, no taken, stall = 1: pc SHALL hold.
REQ-009 RUN, taken, stall = 0: pc SHALL load the selected target at the next edge, and redirect SHALL be 1 for the following cycle.
REQ-010 RUN, taken, stall = 1: the selected target SHALL be latched into an internal pending register, pc SHALL hold, and the state SHALL go to PEND.
REQ-011 PEND, stall = 1: pc SHALL hold.
REQ-012 PEND, stall = 0: pc SHALL load the pending target, the state SHALL return to RUN, and redirect SHALL pulse for the next cycle.
REQ-013 taken1 or taken2 while in PEND SHALL be ignored; this is an illegal condition, flagged by a bench assertion.
REQ-014 flush_if and flush_id SHALL be combinational, equal to 1 in any RUN cycle with taken1 | taken2.
REQ-015 flush_if SHALL also be 1 in every PEND cycle.
REQ-016 Flush SHALL override stall downstream.
REQ-017 kill_ex2 SHALL equal taken1, combinational, because slot 2 is younger than slot 1.
REQ-018 fetch_valid2 SHALL equal ~pc[2].
REQ-019 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFF8 + 8 = 32'h0000_0000, no flag.
REQ-020 taken_count SHALL increment once per accepted redirect (REQ-009 and REQ-010) and SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-021 On rst = 1 at a clock edge, all of the following SHALL hold:
- pc = RESET_PC.
- state = RUN.
- pending register = 0.
- redirect = 0.
- taken_count = 0.
REQ-022 rst SHALL take priority over taken and stall, including while in PEND; a pending target SHALL be discarded.
REQ-023 During reset, the combinational outputs SHALL follow their equations; the pipeline ignores them under rst.

Configuration
REQ-024 Macro BRANCH_STATS_EN SHALL control the statistics counter.
- Defined: taken_count SHALL behave per REQ-020.
- Undefined: taken_count SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-025 Sequential fetch: reset, RESET_PC = 0, stall = 0 for 3 cycles -> pc = 0, 8, 16, 24; fetch_valid2 = 1 throughout.
REQ-026 Dual taken: taken1 = taken2 = 1, target1 = 32'h100, target2 = 32'h200 -> same cycle flush_if = flush_id = kill_ex2 = 1; next pc = 32'h100, redirect = 1; taken_count + 1.
REQ-027 Misaligned target: taken2 = 1, target2 = 32'h107 -> next pc = 32'h104, fetch_valid2 = 0, then pc = 32'h108, fetch_valid2 = 1.
REQ-028 Stalled redirect: stall = 1, taken1 = 1, target1 = 32'h40; stall held 3 cycles -> pc holds and flush_if = 1 in PEND; stall drops -> pc = 32'h40 next edge and redirect pulses once.
REQ-029 Reset in PEND: enter PEND with target 32'h80, assert rst -> pc = RESET_PC, state RUN; after rst releases, pc never takes 32'h80.
REQ-030 Wrap and saturation: pc = 32'hFFFF_FFF8 advances to 0; with BRANCH_STATS_EN defined and the counter forced to 32'hFFFF_FFFF, a taken stays at 32'hFFFF_FFFF; with the macro undefined, taken_count = 0 always.
